// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : div_pkg                                                          |
// | Brief   : Shared state encoding and width constants for the seq divider.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package div_pkg;

  localparam int c_dividend_width = 54;
  localparam int c_divisor_width  = 27;
  localparam int c_cnt_width      = $clog2(c_dividend_width);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter must hold DIVIDEND_WIDTH-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : div_step                                                          |
// | Brief  : One combinational restoring-division iteration.                   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module div_step #(
  parameter int DIVISOR_WIDTH = 27
) (
  input  logic [DIVISOR_WIDTH:0]   r,
  input  logic                     q_msb,
  input  logic [DIVISOR_WIDTH-1:0] d,
  output logic [DIVISOR_WIDTH:0]   r_next,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH+1:0] w_shift_full;
  logic [DIVISOR_WIDTH:0]   w_shift;

  // The partial remainder stays below d, so its top bit is zero and the
  // subtraction can be done at DIVISOR_WIDTH+1 bits.
  assign w_shift_full = {r, q_msb};
  assign w_shift      = {r[DIVISOR_WIDTH-1:0], q_msb};
  assign q_bit        = (w_shift_full >= {2'b00, d});
  assign r_next       = q_bit ? (w_shift - {1'b0, d}) : w_shift;

endmodule
`default_nettype wire

// File: rtl/seq_div_54x27.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : seq_div_54x27                                                     |
// | Brief  : Iterative radix-2 restoring divider with valid/ready handshake.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module seq_div_54x27
  import div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = c_dividend_width,
  parameter int DIVISOR_WIDTH  = c_divisor_width,
  parameter bit SIGNED         = 1'b0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int                 c_cnt_w    = cnt_width(DIVIDEND_WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DIVIDEND_WIDTH - 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [c_cnt_w-1:0]          r_cnt;
  logic [DIVIDEND_WIDTH-1:0]   r_q;
  logic [DIVISOR_WIDTH:0]      r_rem;
  logic [DIVISOR_WIDTH-1:0]    r_d;
  logic                        r_neg_q;
  logic                        r_neg_r;
  logic [DIVIDEND_WIDTH-1:0]   r_quotient;
  logic [DIVISOR_WIDTH-1:0]    r_remainder;
  logic                        r_out_valid;
  logic                        r_div_by_zero;

  logic                        w_divisor_zero;
  logic                        w_dividend_neg;
  logic                        w_divisor_neg;
  logic [DIVIDEND_WIDTH-1:0]   w_dividend_mag;
  logic [DIVISOR_WIDTH-1:0]    w_divisor_mag;
  logic [DIVISOR_WIDTH:0]      w_rem_next;
  logic                        w_q_bit;

  assign w_divisor_zero = (divisor == '0);
  assign w_dividend_neg = SIGNED && dividend[DIVIDEND_WIDTH-1];
  assign w_divisor_neg  = SIGNED && divisor[DIVISOR_WIDTH-1];
  assign w_dividend_mag = w_dividend_neg ? -dividend : dividend;
  assign w_divisor_mag  = w_divisor_neg  ? -divisor  : divisor;

  div_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .r      (r_rem),
    .q_msb  (r_q[DIVIDEND_WIDTH-1]),
    .d      (r_d),
    .r_next (w_rem_next),
    .q_bit  (w_q_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = w_divisor_zero ? DONE : CALC;
      CALC:    if (r_cnt == '0) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE:    if (r_out_valid && out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt         <= '0;
      r_q           <= '0;
      r_rem         <= '0;
      r_d           <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_out_valid   <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_q     <= w_dividend_mag;
            r_d     <= w_divisor_mag;
            r_rem   <= '0;
            r_cnt   <= c_cnt_load;
            r_neg_q <= w_dividend_neg ^ w_divisor_neg;
            r_neg_r <= w_dividend_neg;
            // Zero divisor skips iteration and publishes the fixed result now.
            if (w_divisor_zero) begin
              r_quotient    <= '1;
              r_remainder   <= dividend[DIVISOR_WIDTH-1:0];
              r_div_by_zero <= 1'b1;
              r_out_valid   <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[DIVIDEND_WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_quotient    <= r_neg_q ? -r_q : r_q;
          r_remainder   <= r_neg_r ? -r_rem[DIVISOR_WIDTH-1:0] : r_rem[DIVISOR_WIDTH-1:0];
          r_div_by_zero <= 1'b0;
          r_out_valid   <= 1'b1;
        end
        DONE: begin
          if (r_out_valid && out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_div_54x27.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_seq_div_54x27                                                  |
// | Brief  : Unsigned and signed divider instances driven in lockstep and      |
// |          checked against an arithmetic model.                              |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_seq_div_54x27;

  localparam int N = 54;
  localparam int M = 27;

  logic            clk       = 1'b0;
  logic            resetn    = 1'b0;
  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b1;
  logic [N-1:0]    dividend  = '0;
  logic [M-1:0]    divisor   = '0;

  logic [1:0]         in_ready;
  logic [1:0]         out_valid;
  logic [1:0]         dbz;
  logic [1:0][N-1:0]  quo;
  logic [1:0][M-1:0]  rem;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Per-instance scoreboard: index 0 unsigned, index 1 signed.
  bit   [1:0]        busy = '0;
  bit   [1:0]        pend = '0;
  logic [1:0][N-1:0] exp_q;
  logic [1:0][M-1:0] exp_r;
  bit   [1:0]        exp_z;
  int                acc_cyc [2];
  int                exp_lat [2];

  logic [N-1:0] mq;
  logic [M-1:0] mr;
  bit           mz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_div_54x27 #(.DIVIDEND_WIDTH(N), .DIVISOR_WIDTH(M), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready[0]),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid[0]),
    .out_ready(out_ready), .quotient(quo[0]), .remainder(rem[0]),
    .div_by_zero(dbz[0])
  );

  seq_div_54x27 #(.DIVIDEND_WIDTH(N), .DIVISOR_WIDTH(M), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready[1]),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid[1]),
    .out_ready(out_ready), .quotient(quo[1]), .remainder(rem[1]),
    .div_by_zero(dbz[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain integer division: truncation toward zero, remainder takes dividend's sign.
  function automatic void model(input bit sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                                output logic [N-1:0] q, output logic [M-1:0] r, output bit z);
    longint unsigned ua, ub, uq, ur;
    longint          sa, sb, sq, sr;
    logic [63:0]     tq, tr;
    if (b == '0) begin
      q = '1;
      r = a[M-1:0];
      z = 1'b1;
    end else if (!sgn) begin
      ua = 64'(a);
      ub = 64'(b);
      uq = ua / ub;
      ur = ua % ub;
      tq = uq;
      tr = ur;
      q  = tq[N-1:0];
      r  = tr[M-1:0];
      z  = 1'b0;
    end else begin
      sa = {{(64-N){a[N-1]}}, a};
      sb = {{(64-M){b[M-1]}}, b};
      sq = sa / sb;
      sr = sa % sb;
      tq = sq;
      tr = sr;
      q  = tq[N-1:0];
      r  = tr[M-1:0];
      z  = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit ev;
      if (!resetn) begin
        check("reset_q", quo[i], 64'd0);
        check("reset_r", rem[i], 64'd0);
        check("reset_flags", {out_valid[i], dbz[i], in_ready[i]}, 64'b001);
        busy[i] = 1'b0;
        pend[i] = 1'b0;
      end else begin
        ev = pend[i] && ((cyc - acc_cyc[i]) >= exp_lat[i]);
        check("in_ready", in_ready[i], !busy[i]);
        check("out_valid", out_valid[i], ev);
        if (ev && out_valid[i]) begin
          check("quotient", quo[i], exp_q[i]);
          check("remainder", rem[i], exp_r[i]);
          check("div_by_zero", dbz[i], exp_z[i]);
        end
        if (ev && out_ready) begin
          pend[i] = 1'b0;
          busy[i] = 1'b0;
        end else if (in_valid && !busy[i]) begin
          model(i == 1, dividend, divisor, mq, mr, mz);
          exp_q[i]   = mq;
          exp_r[i]   = mr;
          exp_z[i]   = mz;
          busy[i]    = 1'b1;
          pend[i]    = 1'b1;
          acc_cyc[i] = cyc;
          exp_lat[i] = mz ? 1 : N + 2;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy != 2'b00) && (n < 300)) begin
      step();
      n++;
    end
  endtask

  task automatic pin(input string name, input bit sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                     input logic [N-1:0] q_exp, input logic [M-1:0] r_exp, input bit z_exp);
    logic [N-1:0] q;
    logic [M-1:0] r;
    bit           z;
    model(sgn, a, b, q, r, z);
    check({name, "_model_q"}, q, q_exp);
    check({name, "_model_r"}, r, r_exp);
    check({name, "_model_z"}, z, z_exp);
  endtask

  // Present one operand pair for a single cycle, scramble the bus, then drain.
  task automatic run(input string name, input bit sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                     input logic [N-1:0] q_exp, input logic [M-1:0] r_exp, input bit z_exp);
    pin(name, sgn, a, b, q_exp, r_exp, z_exp);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dividend = N'({$urandom(), $urandom()});
    divisor  = M'($urandom());
    wait_idle();
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();

    run("u_1000_7", 1'b0, N'(1000), M'(7), N'(142), M'(6), 1'b0);
    run("u_max", 1'b0, {N{1'b1}}, {M{1'b1}}, N'(134217729), M'(0), 1'b0);
    run("u_5_9", 1'b0, N'(5), M'(9), N'(0), M'(5), 1'b0);

    run("s_m7_2", 1'b1, N'(-7), M'(2), N'(-3), M'(-1), 1'b0);
    run("s_7_m2", 1'b1, N'(7), M'(-2), N'(-3), M'(1), 1'b0);
    run("s_ovf", 1'b1, 54'h20_0000_0000_0000, M'(-1), 54'h20_0000_0000_0000, M'(0), 1'b0);
    run("s_m7_m2", 1'b1, N'(-7), M'(-2), N'(3), M'(-1), 1'b0);

    run("u_div0", 1'b0, N'(32'h1234_5678), M'(0), {N{1'b1}}, 27'h234_5678, 1'b1);

    // Back-pressure: result held, new request ignored, release frees the block.
    pin("u_bp", 1'b0, N'(123456789), M'(1000), N'(123456), M'(789), 1'b0);
    out_ready = 1'b0;
    dividend  = N'(123456789);
    divisor   = M'(1000);
    in_valid  = 1'b1;
    step();
    dividend  = N'(777);
    divisor   = M'(3);
    repeat (N + 3) step();
    repeat (20) step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    step();
    out_ready = 1'b1;

    // Asynchronous reset in the middle of an iteration.
    pin("u_100_10", 1'b0, N'(100), M'(10), N'(10), M'(0), 1'b0);
    dividend = N'(999999);
    divisor  = M'(13);
    in_valid = 1'b1;
    step();
    repeat (30) step();
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_rst_valid", out_valid[i], 64'd0);
      check("async_rst_q", quo[i], 64'd0);
      check("async_rst_r", rem[i], 64'd0);
      check("async_rst_ready", {dbz[i], in_ready[i]}, 64'b01);
    end
    dividend = N'(100);
    divisor  = M'(10);
    step();
    step();
    resetn = 1'b1;
    step();
    in_valid = 1'b0;
    wait_idle();

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
